time_set_ctrl: RTL and testbench

- Sequences all writes into the time-keeping core.
- Runs a button-driven manual edit FSM: month, then day, then hour, then minute, then commit.
- Arbitrates edit sessions against UART time-load requests.
- Drives the core's single load_settings strobe and load_* buses. Exports the active edit field so the display can blink the digit pair being edited.

---
 rtl/time_set_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: sequences every write into the time-keeping core,
// running the button-driven manual edit session and arbitrating UART time loads.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] actual_month,
  input  logic [4:0] actual_day,
  input  logic [4:0] actual_hour,
  input  logic [5:0] actual_min,
  input  logic       uart_valid,
  output logic       uart_ready,
  input  logic [3:0] uart_month,
  input  logic [4:0] uart_day,
  input  logic [4:0] uart_hour,
  input  logic [5:0] uart_min,
  input  logic [5:0] uart_sec,
  output logic       uart_err,
  output logic       load_settings,
  output logic [3:0] load_month,
  output logic [4:0] load_day,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [2:0] edit_field,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_MONTH,
    S_SET_DAY,
    S_SET_HOUR,
    S_SET_MIN,
    S_COMMIT,
    S_UART_CHK
  } state_e;

  // No leap years: February is always 28 days.
  function automatic logic [4:0] days_in_month(input logic [3:0] month);
    case (month)
      4'd2:                    days_in_month = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             mode_q, up_q, down_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edit_month_q, edit_month_d;
  logic [4:0]       edit_day_q, edit_day_d;
  logic [4:0]       edit_hour_q, edit_hour_d;
  logic [5:0]       edit_min_q, edit_min_d;
  logic             load_settings_q, load_settings_d;
  logic             uart_err_q, uart_err_d;
  logic [3:0]       load_month_q, load_month_d;
  logic [4:0]       load_day_q, load_day_d;
  logic [4:0]       load_hour_q, load_hour_d;
  logic [5:0]       load_min_q, load_min_d;
  logic [5:0]       load_sec_q, load_sec_d;

  logic mode_edge, up_edge, down_edge, any_edge, step_up, step_dn;
  logic uart_ok;
  logic [4:0] edit_dim;

  assign mode_edge = btn_mode & ~mode_q;
  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;
  assign any_edge  = mode_edge | up_edge | down_edge;
  // Mode outranks up/down, and opposing up/down edges cancel.
  assign step_up   = up_edge & ~down_edge & ~mode_edge;
  assign step_dn   = down_edge & ~up_edge & ~mode_edge;
  assign edit_dim  = days_in_month(edit_month_q);

  assign uart_ok = (uart_month >= 4'd1) && (uart_month <= 4'd12) &&
                   (uart_day >= 5'd1) && (uart_day <= days_in_month(uart_month)) &&
                   (uart_hour <= 5'd23) && (uart_min <= 6'd59) && (uart_sec <= 6'd59);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = '0;
    edit_month_d    = edit_month_q;
    edit_day_d      = edit_day_q;
    edit_hour_d     = edit_hour_q;
    edit_min_d      = edit_min_q;
    load_settings_d = 1'b0;
    uart_err_d      = 1'b0;
    load_month_d    = load_month_q;
    load_day_d      = load_day_q;
    load_hour_d     = load_hour_q;
    load_min_d      = load_min_q;
    load_sec_d      = load_sec_q;

    // Shared inactivity handling for all edit states; mode edges below override state_d.
    if (state_q inside {S_SET_MONTH, S_SET_DAY, S_SET_HOUR, S_SET_MIN}) begin
      if (any_edge) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (uart_valid) begin
          // The record is range-checked as it is accepted so the strobe lands in UART_CHK.
          state_d = S_UART_CHK;
          if (uart_ok) begin
            load_settings_d = 1'b1;
            load_month_d    = uart_month;
            load_day_d      = uart_day;
            load_hour_d     = uart_hour;
            load_min_d      = uart_min;
            load_sec_d      = uart_sec;
          end else begin
            uart_err_d = 1'b1;
          end
        end else if (mode_edge) begin
          state_d      = S_SET_MONTH;
          edit_month_d = actual_month;
          edit_day_d   = actual_day;
          edit_hour_d  = actual_hour;
          edit_min_d   = actual_min;
        end
      end

      S_SET_MONTH: begin
        if (mode_edge) begin
          state_d = S_SET_DAY;
          if (edit_day_q > edit_dim) edit_day_d = edit_dim;
        end else if (step_up) begin
          edit_month_d = (edit_month_q >= 4'd12) ? 4'd1 : edit_month_q + 4'd1;
        end else if (step_dn) begin
          edit_month_d = (edit_month_q <= 4'd1) ? 4'd12 : edit_month_q - 4'd1;
        end
      end

      S_SET_DAY: begin
        if (mode_edge) begin
          state_d = S_SET_HOUR;
        end else if (step_up) begin
          edit_day_d = (edit_day_q >= edit_dim) ? 5'd1 : edit_day_q + 5'd1;
        end else if (step_dn) begin
          edit_day_d = (edit_day_q <= 5'd1) ? edit_dim : edit_day_q - 5'd1;
        end
      end

      S_SET_HOUR: begin
        if (mode_edge) begin
          state_d = S_SET_MIN;
        end else if (step_up) begin
          edit_hour_d = (edit_hour_q >= 5'd23) ? 5'd0 : edit_hour_q + 5'd1;
        end else if (step_dn) begin
          edit_hour_d = (edit_hour_q == 5'd0) ? 5'd23 : edit_hour_q - 5'd1;
        end
      end

      S_SET_MIN: begin
        if (mode_edge) begin
          state_d         = S_COMMIT;
          load_settings_d = 1'b1;
          load_month_d    = edit_month_q;
          load_day_d      = edit_day_q;
          load_hour_d     = edit_hour_q;
          load_min_d      = edit_min_q;
          load_sec_d      = 6'd0;
        end else if (step_up) begin
          edit_min_d = (edit_min_q >= 6'd59) ? 6'd0 : edit_min_q + 6'd1;
        end else if (step_dn) begin
          edit_min_d = (edit_min_q == 6'd0) ? 6'd59 : edit_min_q - 6'd1;
        end
      end

      S_COMMIT, S_UART_CHK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      mode_q          <= 1'b0;
      up_q            <= 1'b0;
      down_q          <= 1'b0;
      cnt_q           <= '0;
      edit_month_q    <= 4'd1;
      edit_day_q      <= 5'd1;
      edit_hour_q     <= 5'd0;
      edit_min_q      <= 6'd0;
      load_settings_q <= 1'b0;
      uart_err_q      <= 1'b0;
      load_month_q    <= 4'd1;
      load_day_q      <= 5'd1;
      load_hour_q     <= 5'd0;
      load_min_q      <= 6'd0;
      load_sec_q      <= 6'd0;
    end else begin
      state_q         <= state_d;
      mode_q          <= btn_mode;
      up_q            <= btn_up;
      down_q          <= btn_down;
      cnt_q           <= cnt_d;
      edit_month_q    <= edit_month_d;
      edit_day_q      <= edit_day_d;
      edit_hour_q     <= edit_hour_d;
      edit_min_q      <= edit_min_d;
      load_settings_q <= load_settings_d;
      uart_err_q      <= uart_err_d;
      load_month_q    <= load_month_d;
      load_day_q      <= load_day_d;
      load_hour_q     <= load_hour_d;
      load_min_q      <= load_min_d;
      load_sec_q      <= load_sec_d;
    end
  end

  always_comb begin
    edit_field = 3'd0;
    case (state_q)
      S_SET_MONTH: edit_field = 3'd1;
      S_SET_DAY:   edit_field = 3'd2;
      S_SET_HOUR:  edit_field = 3'd3;
      S_SET_MIN:   edit_field = 3'd4;
      default:     edit_field = 3'd0;
    endcase
  end

  assign uart_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign uart_err      = uart_err_q;
  assign load_settings = load_settings_q;
  assign load_month    = load_month_q;
  assign load_day      = load_day_q;
  assign load_hour     = load_hour_q;
  assign load_min      = load_min_q;
  assign load_sec      = load_sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: expected load records are queued when
// stimulus is driven and matched against each load_settings strobe.
module tb_time_set_ctrl;

  typedef struct packed {
    logic [3:0] m;
    logic [4:0] d;
    logic [4:0] h;
    logic [5:0] mi;
    logic [5:0] s;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down;
  logic [3:0] actual_month;
  logic [4:0] actual_day, actual_hour;
  logic [5:0] actual_min;
  logic       uart_valid, uart_ready;
  logic [3:0] uart_month;
  logic [4:0] uart_day, uart_hour;
  logic [5:0] uart_min, uart_sec;
  logic       uart_err, load_settings;
  logic [3:0] load_month;
  logic [4:0] load_day, load_hour;
  logic [5:0] load_min, load_sec;
  logic [2:0] edit_field;
  logic       busy;

  int   checks   = 0;
  int   failures = 0;
  rec_t sb[$];
  logic last_load = 1'b0;

  time_set_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .actual_month(actual_month), .actual_day(actual_day),
    .actual_hour(actual_hour), .actual_min(actual_min),
    .uart_valid(uart_valid), .uart_ready(uart_ready),
    .uart_month(uart_month), .uart_day(uart_day), .uart_hour(uart_hour),
    .uart_min(uart_min), .uart_sec(uart_sec), .uart_err(uart_err),
    .load_settings(load_settings), .load_month(load_month), .load_day(load_day),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .edit_field(edit_field), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(int m, int d, int h, int mi, int s);
    rec_t r;
    r.m = 4'(m); r.d = 5'(d); r.h = 5'(h); r.mi = 6'(mi); r.s = 6'(s);
    return r;
  endfunction

  function automatic bit rec_ok(rec_t r);
    int mdays[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (r.m < 1 || r.m > 12) return 1'b0;
    return (r.d >= 1) && (int'(r.d) <= mdays[r.m]) && (r.h < 24) && (r.mi < 60) && (r.s < 60);
  endfunction

  function automatic rec_t load_bus();
    return {load_month, load_day, load_hour, load_min, load_sec};
  endfunction

  // One clock; the scoreboard watches load_settings on the falling edge.
  task automatic tick();
    rec_t exp_r, got_r;
    @(negedge clk);
    if (rst) begin
      if (load_settings) begin
        checks++;
        if (last_load) begin
          failures++;
          $display("FAIL back_to_back_load: load_settings high in two consecutive cycles");
        end
        checks++;
        got_r = load_bus();
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load: got %h with nothing expected", got_r);
        end else begin
          exp_r = sb.pop_front();
          if (got_r !== exp_r) begin
            failures++;
            $display("FAIL load_values: got m=%0d d=%0d h=%0d mi=%0d s=%0d expected m=%0d d=%0d h=%0d mi=%0d s=%0d",
                     got_r.m, got_r.d, got_r.h, got_r.mi, got_r.s,
                     exp_r.m, exp_r.d, exp_r.h, exp_r.mi, exp_r.s);
          end
        end
      end
      last_load = load_settings;
    end else begin
      last_load = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m; btn_up = u; btn_down = d;
    tick();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick();
  endtask

  task automatic set_actual(input rec_t r);
    actual_month = r.m; actual_day = r.d; actual_hour = r.h; actual_min = r.mi;
  endtask

  task automatic drive_uart(input rec_t r);
    uart_month = r.m; uart_day = r.d; uart_hour = r.h; uart_min = r.mi; uart_sec = r.s;
  endtask

  task automatic check_field(input string name, input logic [2:0] exp_f);
    checks++;
    if (edit_field !== exp_f) begin
      failures++;
      $display("FAIL %s: edit_field got %0d expected %0d", name, edit_field, exp_f);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected load(s) never seen", name, sb.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({load_settings, uart_err, edit_field, busy, uart_ready} !== 7'b0_0_000_0_1) begin
      failures++;
      $display("FAIL %s: ctrl got %b expected 0000001", name,
               {load_settings, uart_err, edit_field, busy, uart_ready});
    end
    checks++;
    if (load_bus() !== mk(1, 1, 0, 0, 0)) begin
      failures++;
      $display("FAIL %s: load bus got %h expected %h", name, load_bus(), mk(1, 1, 0, 0, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; uart_valid = 1'b0;
    set_actual(mk(1, 1, 0, 0, 0));
    drive_uart(mk(1, 1, 0, 0, 0));
    repeat (3) tick();
    check_reset_values("reset_asserted");
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values("reset_released");
  endtask

  task automatic test_manual_edit();
    set_actual(mk(8, 1, 4, 20, 0));
    press(1, 0, 0);
    check_field("manual_enter_month", 3'd1);
    repeat (5) press(0, 1, 0);
    press(1, 0, 0);
    check_field("manual_day", 3'd2);
    press(0, 0, 1);
    press(1, 0, 0);
    press(1, 0, 0);
    check_field("manual_min", 3'd4);
    repeat (40) press(0, 1, 0);
    sb.push_back(mk(1, 31, 4, 0, 0));
    btn_mode = 1'b1;
    tick();
    checks++;
    if ({load_settings, busy, edit_field} !== 5'b1_1_000) begin
      failures++;
      $display("FAIL commit_latency: {load,busy,field} got %b expected 11000",
               {load_settings, busy, edit_field});
    end
    btn_mode = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL manual_idle_after: busy got %b expected 0", busy);
    end
    check_sb_empty("manual_commit");
    repeat (3) tick();
    checks++;
    if (load_bus() !== mk(1, 31, 4, 0, 0)) begin
      failures++;
      $display("FAIL load_hold: got %h expected %h", load_bus(), mk(1, 31, 4, 0, 0));
    end
  endtask

  task automatic test_day_clamp();
    set_actual(mk(1, 31, 10, 0, 0));
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    sb.push_back(mk(2, 28, 10, 0, 0));
    press(1, 0, 0);
    check_sb_empty("day_clamp");
  endtask

  task automatic test_wraps();
    set_actual(mk(1, 15, 0, 0, 0));
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 1, 1);
    press(1, 1, 0);
    check_field("mode_beats_up", 3'd2);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    sb.push_back(mk(12, 14, 23, 59, 0));
    press(1, 0, 0);
    check_sb_empty("down_wraps");
  endtask

  task automatic test_uart_records();
    rec_t recs[11];
    bit   ok;
    recs = '{mk(12, 25, 23, 59, 58), mk(4, 31, 10, 0, 0), mk(1, 1, 24, 0, 0),
             mk(2, 29, 1, 1, 1), mk(2, 28, 1, 1, 1), mk(13, 1, 0, 0, 0),
             mk(0, 5, 0, 0, 0), mk(6, 0, 0, 0, 0), mk(7, 31, 0, 60, 0),
             mk(7, 31, 0, 0, 60), mk(11, 30, 0, 59, 59)};
    foreach (recs[i]) begin
      ok = rec_ok(recs[i]);
      drive_uart(recs[i]);
      uart_valid = 1'b1;
      checks++;
      if (uart_ready !== 1'b1) begin
        failures++;
        $display("FAIL uart_ready_idle[%0d]: got %b expected 1", i, uart_ready);
      end
      if (ok) sb.push_back(recs[i]);
      tick();
      uart_valid = 1'b0;
      checks++;
      if ({load_settings, uart_err, uart_ready} !== {ok, !ok, 1'b0}) begin
        failures++;
        $display("FAIL uart_response[%0d]: {load,err,ready} got %b expected %b",
                 i, {load_settings, uart_err, uart_ready}, {ok, !ok, 1'b0});
      end
      tick();
      checks++;
      if ({uart_err, busy} !== 2'b00) begin
        failures++;
        $display("FAIL uart_err_pulse[%0d]: {err,busy} got %b expected 00", i, {uart_err, busy});
      end
    end
    check_sb_empty("uart_records");
  endtask

  task automatic test_arbitration();
    bit accepted;
    set_actual(mk(5, 5, 5, 5, 0));
    drive_uart(mk(3, 3, 3, 3, 3));
    sb.push_back(mk(3, 3, 3, 3, 3));
    uart_valid = 1'b1;
    btn_mode = 1'b1;
    tick();
    uart_valid = 1'b0;
    btn_mode = 1'b0;
    tick();
    checks++;
    if ({busy, edit_field} !== 4'b0_000) begin
      failures++;
      $display("FAIL uart_beats_mode: {busy,field} got %b expected 0000", {busy, edit_field});
    end
    check_sb_empty("uart_beats_mode_load");

    repeat (3) press(1, 0, 0);
    check_field("arb_set_hour", 3'd3);
    drive_uart(mk(6, 7, 8, 9, 10));
    uart_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (uart_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_held_off[%0d]: got %b expected 0", i, uart_ready);
      end
      tick();
    end
    press(1, 0, 0);
    checks++;
    if (uart_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_held_off_min: got %b expected 0", uart_ready);
    end
    sb.push_back(mk(5, 5, 5, 5, 0));
    sb.push_back(mk(6, 7, 8, 9, 10));
    press(1, 0, 0);
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (uart_ready) begin
        tick();
        uart_valid = 1'b0;
        accepted = 1'b1;
      end else begin
        tick();
      end
    end
    uart_valid = 1'b0;
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL held_uart_accept: record not accepted within 10 cycles after commit");
    end
    tick();
    check_sb_empty("held_uart_after_commit");
  endtask

  task automatic test_timeout();
    set_actual(mk(3, 10, 12, 30, 0));
    press(1, 0, 0);
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    repeat (99) tick();
    check_field("timeout_not_yet", 3'd2);
    tick();
    check_field("timeout_expired", 3'd0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    tick();
    check_sb_empty("timeout_no_load");
  endtask

  task automatic test_reset_mid_session();
    set_actual(mk(9, 9, 9, 9, 0));
    repeat (4) press(1, 0, 0);
    check_field("reset_mid_set_min", 3'd4);
    rst = 1'b0;
    #1;
    check_reset_values("reset_mid_async");
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_mid_release");
    check_sb_empty("reset_mid_no_load");
  endtask

  initial begin
    test_reset();
    test_manual_edit();
    test_day_clamp();
    test_wraps();
    test_uart_records();
    test_arbitration();
    test_timeout();
    test_reset_mid_session();
    check_sb_empty("final_scoreboard");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
